// File: rtl/hazard_pkg.sv
// Shared opcode constants and mul/div FSM state encoding for the pipeline hazard controller.
package hazard_pkg;

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [2:0] OP_CF_PREFIX = 3'b110;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/hz_scoreboard.sv
// Per-register load countdown; reports whether each ID source must wait for a load result.
module hz_scoreboard #(
    parameter  int NREG     = 32,
    parameter  int LOAD_LAT = 1,
    localparam int RAW      = $clog2(NREG)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           ld_ex,
    input  logic           ex_hold,
    input  logic [RAW-1:0] ld_rd,
    input  logic [RAW-1:0] rs1_addr,
    input  logic [RAW-1:0] rs2_addr,
    output logic           rs1_pend,
    output logic           rs2_pend
);

    localparam int CW = $clog2(LOAD_LAT + 1);

    logic [CW-1:0] cnt_q [NREG];
    logic          set_en;

    assign set_en = ld_ex && !ex_hold && (ld_rd != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the count array is reset element by element; a stale count after reset would stall the pipe.
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else begin
            // NOTE: state updates use <= so every element samples the same pre-edge values.
            for (int r = 0; r < NREG; r++) begin
                if (set_en && (ld_rd == RAW'(r))) cnt_q[r] <= CW'(LOAD_LAT);
                else if (cnt_q[r] != '0)          cnt_q[r] <= cnt_q[r] - CW'(1);
            end
        end
    end

    // The load in EX supplies the first stall cycle; a count of 1 means the value is bypassable now.
    assign rs1_pend = (rs1_addr != '0) &&
                      ((cnt_q[rs1_addr] > CW'(1)) || (ld_ex && (ld_rd == rs1_addr)));
    assign rs2_pend = (rs2_addr != '0) &&
                      ((cnt_q[rs2_addr] > CW'(1)) || (ld_ex && (ld_rd == rs2_addr)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: branch mispredict redirect, mul/div occupancy FSM,
// load-use stalls and saturating performance counters.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter  int XLEN     = 32,
    parameter  int NREG     = 32,
    parameter  int LOAD_LAT = 1,
    parameter  int MD_LAT   = 4,
    parameter  int CNT_W    = 16,
    localparam int RAW      = $clog2(NREG)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_id_i,
    input  logic             valid_ex_i,
    input  logic [RAW-1:0]   rs1_id_i,
    input  logic [RAW-1:0]   rs2_id_i,
    input  logic             rs1_used_i,
    input  logic             rs2_used_i,
    input  logic [RAW-1:0]   rd_ex_i,
    input  logic [6:0]       op_ex_i,
    input  logic             md_start_ex_i,
    input  logic             pc_sel_ex_i,
    input  logic [XLEN-1:0]  alu_i,
    input  logic [XLEN-1:0]  pc_ex_i,
    input  logic [XLEN-1:0]  pc_id_i,
    output logic             stall_pc_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             md_busy_o,
    output logic [CNT_W-1:0] mispred_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int MD_W = $clog2(MD_LAT);

    md_state_e       md_state_q;
    logic [MD_W-1:0] md_cnt_q;
    logic [XLEN-1:0] target;
    logic            mispredict;
    logic            ld_ex;
    logic            rs1_pend;
    logic            rs2_pend;
    logic            load_use;

    assign target = pc_sel_ex_i ? alu_i : pc_ex_i + XLEN'(4);
    assign ld_ex  = valid_ex_i && (op_ex_i == OP_LOAD);

    // Decisions are qualified with rst_ni so every output stays low while reset is held.
    assign mispredict = rst_ni && valid_ex_i && (op_ex_i[6:4] == OP_CF_PREFIX) && (target != pc_id_i);
    assign load_use   = rst_ni && valid_id_i &&
                        ((rs1_used_i && rs1_pend) || (rs2_used_i && rs2_pend));

    hz_scoreboard #(
        .NREG     (NREG),
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .ld_ex    (ld_ex),
        .ex_hold  (stall_ex_o),
        .ld_rd    (rd_ex_i),
        .rs1_addr (rs1_id_i),
        .rs2_addr (rs2_id_i),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        stall_pc_o    = 1'b0;
        stall_id_o    = 1'b0;
        stall_ex_o    = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        if (mispredict) begin
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
        end else if (md_state_q == MD_BUSY) begin
            stall_pc_o = 1'b1;
            stall_id_o = 1'b1;
            stall_ex_o = 1'b1;
        end else if (load_use) begin
            stall_pc_o    = 1'b1;
            stall_id_o    = 1'b1;
            flush_id_ex_o = 1'b1;
        end
    end

    assign redirect_o    = mispredict;
    assign redirect_pc_o = mispredict ? target : '0;
    assign md_busy_o     = (md_state_q != MD_IDLE);

    // The issue cycle plus MD_LAT-1 BUSY cycles give MD_LAT cycles of EX occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            md_state_q <= MD_IDLE;
            md_cnt_q   <= '0;
        end else begin
            case (md_state_q)
                MD_IDLE: begin
                    if (md_start_ex_i && valid_ex_i) begin
                        md_state_q <= MD_BUSY;
                        md_cnt_q   <= MD_W'(MD_LAT - 2);
                    end
                end
                MD_BUSY: begin
                    if (md_cnt_q == '0) md_state_q <= MD_DONE;
                    else                md_cnt_q   <= md_cnt_q - MD_W'(1);
                end
                MD_DONE: md_state_q <= MD_IDLE;
                default: md_state_q <= MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mispred_cnt_o <= '0;
            stall_cnt_o   <= '0;
        end else begin
            if (mispredict && (mispred_cnt_o != '1)) mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
            if (stall_pc_o && (stall_cnt_o != '1))   stall_cnt_o   <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (LOAD_LAT=2, MD_LAT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

    localparam int XLEN  = 32;
    localparam int RAW   = 5;
    localparam int CNT_W = 4;

    // Control vector order: stall_pc, stall_id, stall_ex, flush_if_id, flush_id_ex, redirect, md_busy
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [6:0] C_MP   = 7'b0001110;
    localparam logic [6:0] C_BUSY = 7'b1110001;
    localparam logic [6:0] C_DONE = 7'b0000001;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             valid_id_i, valid_ex_i;
    logic [RAW-1:0]   rs1_id_i, rs2_id_i, rd_ex_i;
    logic             rs1_used_i, rs2_used_i;
    logic [6:0]       op_ex_i;
    logic             md_start_ex_i, pc_sel_ex_i;
    logic [XLEN-1:0]  alu_i, pc_ex_i, pc_id_i;
    logic             stall_pc_o, stall_id_o, stall_ex_o;
    logic             flush_if_id_o, flush_id_ex_o, redirect_o, md_busy_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic [CNT_W-1:0] mispred_cnt_o, stall_cnt_o;
    logic [6:0]       ctl;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    assign ctl = {stall_pc_o, stall_id_o, stall_ex_o, flush_if_id_o, flush_id_ex_o, redirect_o, md_busy_o};

    pipe_hazard_ctrl #(
        .XLEN     (XLEN),
        .NREG     (32),
        .LOAD_LAT (2),
        .MD_LAT   (4),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .valid_id_i    (valid_id_i),
        .valid_ex_i    (valid_ex_i),
        .rs1_id_i      (rs1_id_i),
        .rs2_id_i      (rs2_id_i),
        .rs1_used_i    (rs1_used_i),
        .rs2_used_i    (rs2_used_i),
        .rd_ex_i       (rd_ex_i),
        .op_ex_i       (op_ex_i),
        .md_start_ex_i (md_start_ex_i),
        .pc_sel_ex_i   (pc_sel_ex_i),
        .alu_i         (alu_i),
        .pc_ex_i       (pc_ex_i),
        .pc_id_i       (pc_id_i),
        .stall_pc_o    (stall_pc_o),
        .stall_id_o    (stall_id_o),
        .stall_ex_o    (stall_ex_o),
        .flush_if_id_o (flush_if_id_o),
        .flush_id_ex_o (flush_id_ex_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .md_busy_o     (md_busy_o),
        .mispred_cnt_o (mispred_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [6:0] op, input logic [RAW-1:0] rd);
        valid_ex_i = v;
        op_ex_i    = op;
        rd_ex_i    = rd;
    endtask

    task automatic set_id(input logic v, input logic [RAW-1:0] r1, input logic u1,
                          input logic [RAW-1:0] r2, input logic u2);
        valid_id_i = v;
        rs1_id_i   = r1;
        rs1_used_i = u1;
        rs2_id_i   = r2;
        rs2_used_i = u2;
    endtask

    task automatic set_br(input logic sel, input logic [31:0] alu, input logic [31:0] pce,
                          input logic [31:0] pci);
        pc_sel_ex_i = sel;
        alu_i       = alu;
        pc_ex_i     = pce;
        pc_id_i     = pci;
    endtask

    task automatic quiet();
        set_ex(1'b0, 7'd0, 5'd0);
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        set_br(1'b0, 32'd0, 32'd0, 32'd0);
        md_start_ex_i = 1'b0;
    endtask

    initial begin
        quiet();

        // Reset state
        #3;
        check("reset_ctl", ctl, C_NONE);
        check("reset_rpc", redirect_pc_o, 32'd0);
        check("reset_mcnt", mispred_cnt_o, 4'd0);
        check("reset_scnt", stall_cnt_o, 4'd0);
        #9 rst_ni = 1'b1;
        tick();
        check("post_reset_ctl", ctl, C_NONE);

        // Load-use on rs1=5: two stall cycles
        set_ex(1'b1, OP_LD, 5'd5);
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
        settle();
        check("lu_cyc0", ctl, C_LU);
        tick();
        set_ex(1'b0, 7'd0, 5'd0);
        settle();
        check("lu_cyc1", ctl, C_LU);
        tick();
        settle();
        check("lu_cyc2", ctl, C_NONE);
        check("lu_scnt", stall_cnt_o, 4'd2);

        // Back-to-back loads to x7 reload the count
        set_ex(1'b1, OP_LD, 5'd7);
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0);
        settle();
        check("reload_a", ctl, C_NONE);
        tick();
        settle();
        check("reload_b", ctl, C_NONE);
        tick();
        set_ex(1'b0, 7'd0, 5'd0);
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
        settle();
        check("reload_c", ctl, C_LU);
        tick();
        settle();
        check("reload_d", ctl, C_NONE);
        check("reload_scnt", stall_cnt_o, 4'd3);

        // x0 never stalls
        set_ex(1'b1, OP_LD, 5'd0);
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        settle();
        check("x0_ex", ctl, C_NONE);
        tick();
        set_ex(1'b0, 7'd0, 5'd0);
        settle();
        check("x0_next", ctl, C_NONE);

        // Unused rs2 matching a load does not stall
        tick();
        set_ex(1'b1, OP_LD, 5'd9);
        set_id(1'b1, 5'd2, 1'b1, 5'd9, 1'b0);
        settle();
        check("unused_ex", ctl, C_NONE);
        tick();
        set_ex(1'b0, 7'd0, 5'd0);
        settle();
        check("unused_next", ctl, C_NONE);
        tick();
        quiet();
        tick();

        // Mispredict: taken to 0x100 while ID holds 0x24
        set_ex(1'b1, OP_BR, 5'd0);
        set_br(1'b1, 32'h100, 32'h20, 32'h24);
        settle();
        check("mp_ctl", ctl, C_MP);
        check("mp_rpc", redirect_pc_o, 32'h100);
        tick();
        // Not taken: pc_ex+4 equals pc_id
        set_br(1'b0, 32'h100, 32'h20, 32'h24);
        settle();
        check("mp_cnt1", mispred_cnt_o, 4'd1);
        check("nt_ctl", ctl, C_NONE);
        check("nt_rpc", redirect_pc_o, 32'd0);
        tick();
        check("nt_cnt", mispred_cnt_o, 4'd1);

        // Mispredict with a pending load-use on rs1: flush only
        quiet();
        set_ex(1'b1, OP_LD, 5'd6);
        settle();
        check("prio_load", ctl, C_NONE);
        tick();
        set_ex(1'b1, OP_BR, 5'd0);
        set_br(1'b1, 32'h200, 32'h40, 32'h24);
        set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b0);
        settle();
        check("prio_ctl", ctl, C_MP);
        check("prio_rpc", redirect_pc_o, 32'h200);
        tick();
        quiet();
        settle();
        check("prio_mcnt", mispred_cnt_o, 4'd2);
        check("prio_scnt", stall_cnt_o, 4'd3);
        tick();
        tick();

        // Mul/div, start held for 3 cycles
        set_ex(1'b1, OP_ALU, 5'd1);
        md_start_ex_i = 1'b1;
        settle();
        check("md_issue", ctl, C_NONE);
        tick();
        settle();
        check("md_busy1", ctl, C_BUSY);
        tick();
        settle();
        check("md_busy2", ctl, C_BUSY);
        tick();
        md_start_ex_i = 1'b0;
        settle();
        check("md_busy3", ctl, C_BUSY);
        tick();
        settle();
        check("md_done", ctl, C_DONE);
        tick();
        settle();
        check("md_idle", ctl, C_NONE);
        check("md_scnt", stall_cnt_o, 4'd6);
        tick();
        settle();
        check("md_norestart", ctl, C_NONE);

        // Reset in BUSY with 2 cycles left
        md_start_ex_i = 1'b1;
        tick();
        settle();
        check("rst_busy", ctl, C_BUSY);
        rst_ni = 1'b0;
        settle();
        check("rst_ctl", ctl, C_NONE);
        check("rst_rpc", redirect_pc_o, 32'd0);
        check("rst_mcnt", mispred_cnt_o, 4'd0);
        check("rst_scnt", stall_cnt_o, 4'd0);
        quiet();
        tick();
        rst_ni = 1'b1;
        tick();
        settle();
        check("rst_rel1", ctl, C_NONE);
        tick();
        settle();
        check("rst_rel2", ctl, C_NONE);

        // 20 consecutive mispredicts saturate the 4-bit counter
        set_ex(1'b1, OP_BR, 5'd0);
        set_br(1'b1, 32'h300, 32'h50, 32'h24);
        for (int i = 0; i < 20; i++) tick();
        check("sat_ctl", ctl, C_MP);
        check("sat_mcnt", mispred_cnt_o, 4'd15);
        tick();
        check("sat_hold", mispred_cnt_o, 4'd15);
        quiet();
        tick();
        check("sat_quiet", mispred_cnt_o, 4'd15);
        check("sat_scnt", stall_cnt_o, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
